// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one 4x4 unsigned array multiplier among NREQ requesters.
// Latency: handshake in cycle N, product registered at the end of N+1, rsp_valid from N+2.
// Backpressure: while the response is held by rsp_ready=0, no new request is accepted.

// 4x4 unsigned array multiplier, purely combinational.
module mult (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic [3:0] sum_row;
  logic [3:0] next_row;
  logic       carry;
  logic [1:0] fa;

  // One-bit full adder: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    full_add = {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
  endfunction

  // Ripple-carry rows: each row adds the next shifted partial product to the running sum.
  always_comb begin
    p_o      = '0;
    next_row = '0;
    carry    = 1'b0;
    fa       = '0;
    p_o[0]   = a_i[0] & b_i[0];
    sum_row  = {1'b0, a_i[3:1] & {3{b_i[0]}}};
    for (int i = 1; i < 4; i++) begin
      carry = 1'b0;
      for (int j = 0; j < 4; j++) begin
        fa          = full_add(a_i[j] & b_i[i], sum_row[j], carry);
        next_row[j] = fa[0];
        carry       = fa[1];
      end
      p_o[i]  = next_row[0];
      sum_row = {carry, next_row[3:1]};
    end
    p_o[7:4] = sum_row;
  end

endmodule

module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_product,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [15:0]       ops_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [3:0]     op_a_q, op_a_d;
  logic [3:0]     op_b_q, op_b_d;
  logic [7:0]     prod_q, prod_d;
  logic [15:0]    ops_q, ops_d;

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  int             scan_idx;
  logic [3:0]     sel_a;
  logic [3:0]     sel_b;
  logic [7:0]     mult_p;
  logic           req_fire;

  // Round-robin search starting just after the last served requester.
  // Scanning from the farthest candidate back keeps the nearest valid one as the winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = (int'(ptr_q) + k) % NREQ;
      if (req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(scan_idx);
      end
    end
  end

  // Grant only from IDLE; held at zero while reset is asserted so no handshake is seen.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == ST_IDLE && grant_vld) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  assign req_fire = (state_q == ST_IDLE) && grant_vld;
  assign sel_a    = req_a[{grant_idx, 2'b00} +: 4];
  assign sel_b    = req_b[{grant_idx, 2'b00} +: 4];

  mult u_mult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mult_p)
  );

  // Next-state logic: IDLE -> CALC on a grant, CALC -> RESP always, RESP -> IDLE on accept.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    prod_d  = prod_q;
    ops_d   = ops_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          id_d    = grant_idx;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        prod_d  = mult_p;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ptr_d   = id_q;
          ops_d   = ops_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; an asserted reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      prod_q  <= prod_d;
      ops_q   <= ops_d;
    end
  end

  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_id      = id_q;
  assign rsp_product = prod_q;
  assign busy        = (state_q != ST_IDLE);
  assign ops_done    = ops_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed-vector bench for mult_share_arb.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every operation uses fixed cycle timing, so no wait depends on an open-ended DUT event.
module tb_mult_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_product;
  logic              rsp_ready;
  logic              busy;
  logic [15:0]       ops_done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ops  = 0;

  mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_ready   (rsp_ready),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges, check reset outputs, release 1 unit after an edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_ops_done", 32'(ops_done), 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_ops = 0;
  endtask

  // One full operation, entered 1 unit after an edge with the DUT in IDLE.
  // mask: requesters valid; exp_g: expected winner; hold: RESP cycles with rsp_ready=0;
  // extra: requesters that raise valid during CALC only and drop it before IDLE.
  task automatic op(input logic [3:0] mask, input int exp_g, input logic [3:0] a,
                    input logic [3:0] b, input int hold, input logic [3:0] extra);
    int exp_p;
    exp_p     = int'(a) * int'(b);
    req_valid = mask;
    req_a     = {a, a, a, a};
    req_b     = {b, b, b, b};
    rsp_ready = 1'b1;
    @(negedge clk);
    check("grant", 32'(req_ready), 32'(4'b0001 << exp_g));
    @(posedge clk);
    #1;
    // Operand buses change after the handshake; the product must not follow them.
    req_a     = '0;
    req_b     = '0;
    req_valid = mask | extra;
    @(negedge clk);
    check("calc_req_ready", 32'(req_ready), 0);
    check("calc_busy", 32'(busy), 1);
    check("calc_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk);
    #1;
    req_valid = mask;
    rsp_ready = (hold == 0);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_id", 32'(rsp_id), 32'(exp_g));
      check("rsp_product", 32'(rsp_product), 32'(exp_p));
      check("resp_req_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1;
      if (h + 1 == hold) rsp_ready = 1'b1;
    end
    exp_ops++;
    check("idle_busy", 32'(busy), 0);
    check("ops_done", 32'(ops_done), 32'(exp_ops));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Single request from requester 2: 7*9 = 63.
    do_reset();
    op(4'b0100, 2, 4'd7, 4'd9, 0, 4'b0000);

    // Exhaustive products through requester 0 from a fresh reset.
    do_reset();
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op(4'b0001, 0, 4'(x), 4'(y), 0, 4'b0000);
      end
    end
    check("ops_done_256", 32'(ops_done), 256);

    // Round-robin under continuous requests from all four.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      op(4'b1111, n % 4, 4'(n + 3), 4'(13 - n), 0, 4'b0000);
    end
    // After a grant to 1, with 0 and 3 pending, 3 comes next, then 0.
    op(4'b0010, 1, 4'd15, 4'd15, 0, 4'b0000);
    op(4'b1001, 3, 4'd12, 4'd11, 0, 4'b0000);
    op(4'b1001, 0, 4'd5, 4'd6, 0, 4'b0000);

    // Backpressure: response held for five cycles.
    op(4'b0100, 2, 4'd14, 4'd13, 5, 4'b0000);

    // Withdrawn request: requester 1 valid only while busy is never granted.
    op(4'b1000, 3, 4'd9, 4'd8, 0, 4'b0010);
    op(4'b0001, 0, 4'd4, 4'd4, 0, 4'b0010);

    // Reset asserted during CALC.
    req_valid = 4'b0100;
    req_a     = {4{4'd3}};
    req_b     = {4{4'd5}};
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pre_rst_grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_ops = 0;
    check("post_rst_ops_done", 32'(ops_done), 0);
    op(4'b1111, 0, 4'd2, 4'd8, 0, 4'b0000);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
